// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Round-robin conflict resolution is enabled with MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

    // Fixed priority favours data; round-robin favours the port not served last.
    function automatic grant_t pick(
        input logic   ir,
        input logic   dr,
        input grant_t last,
        input logic   rr
    );
        if (ir && dr) begin
            if (rr) return (last == GNT_I) ? GNT_D : GNT_I;
            return GNT_D;
        end
        return dr ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Acknowledge-wait counter for the memory arbiter; saturates at TIMEOUT.
// expired flags the enabled cycle in which the count reaches TIMEOUT.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TOP   = CW'(TIMEOUT);
    localparam logic [CW:0]   LIMIT = (CW + 1)'(TIMEOUT);
    localparam logic [CW:0]   ONE   = (CW + 1)'(1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != TOP) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (({1'b0, count} + ONE) == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter for the single memory req/ack port.
// Define MEM_ARB_RR_EN to alternate grants on simultaneous requests.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    state_t state;
    state_t state_next;
    grant_t grant;
    grant_t win;
    logic   expired;

    // grant doubles as the last-grant history when round-robin is built in
`ifdef MEM_ARB_RR_EN
    assign win = pick(i_req, d_req, grant, 1'b1);
`else
    assign win = pick(i_req, d_req, grant, 1'b0);
`endif

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (state == ST_IDLE),
        .enable  (state == ST_BUSY),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (i_req || d_req)   state_next = ST_BUSY;
            ST_BUSY: if (m_ack || expired) state_next = ST_DONE;
            ST_DONE:                       state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        i_done = 1'b0;
        d_done = 1'b0;
        if (state == ST_DONE) begin
            i_done = (grant == GNT_I);
            d_done = (grant == GNT_D);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            grant   <= GNT_I;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_err   <= 1'b0;
            d_err   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        grant <= win;
                        m_req <= 1'b1;
                        if (win == GNT_D) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            m_we    <= 1'b0;
                            m_addr  <= i_addr;
                        end
                    end
                end
                ST_BUSY: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        if (!m_we) begin
                            if (grant == GNT_I) i_rdata <= m_rdata;
                            else                d_rdata <= m_rdata;
                        end
                    end else if (expired) begin
                        m_req <= 1'b0;
                        if (grant == GNT_I) begin
                            i_err   <= 1'b1;
                            i_rdata <= '0;
                        end else begin
                            d_err <= 1'b1;
                            // a store never touches the load-data register
                            if (!m_we) d_rdata <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    i_err <= 1'b0;
                    d_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a reactive memory model.
// Exercises conflicts, ack-wait latency, read timeouts and reset mid-transaction.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_done, i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done, d_err;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_done  (i_done),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_done  (d_done),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;   // 1 = data port
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   stim_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // requester-side view of what the DUT sampled at the last rising edge
    logic        s_i, s_d, s_dwe;
    logic [31:0] s_iaddr, s_daddr, s_dwdata;

    always @(posedge clk) begin
        cyc++;
        s_i      = i_req;
        s_d      = d_req;
        s_dwe    = d_we;
        s_iaddr  = i_addr;
        s_daddr  = d_addr;
        s_dwdata = d_wdata;
    end

    always @(negedge clk) begin
        if (!n_reset) begin
            i_req = 1'b0;
        end else if (i_req) begin
            if (i_done) i_req = 1'b0;
        end else if (stim_en && $urandom_range(0, 1) == 0) begin
            i_req  = 1'b1;
            i_addr = $urandom & 32'hFFFF_FFFC;
        end
    end

    always @(negedge clk) begin
        if (!n_reset) begin
            d_req = 1'b0;
        end else if (d_req) begin
            if (d_done) d_req = 1'b0;
        end else if (stim_en && $urandom_range(0, 1) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom & 32'hFFFF_FFFC;
            d_wdata = $urandom;
        end
    end

    // memory model plus reference: who should win, when done, what data
    bit          active, to, last_d, wd;
    int          age, w, endc;
    logic [31:0] ackd, mi_last, md_last;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    exp_t        e;

    always @(negedge clk) begin
        m_rdata = $urandom;
        m_ack   = 1'b0;
        if (!n_reset) begin
            active  = 1'b0;
            last_d  = 1'b0;
            mi_last = '0;
            md_last = '0;
        end else if (active) begin
            age++;
            if (age < endc) begin
                chk("m_req_hold", 128'(m_req), 128'(1));
                chk("m_fields_hold", {m_we, m_addr, m_wdata},
                    {h_we, h_addr, h_wdata});
            end else begin
                chk("m_req_drop", 128'(m_req), 128'(0));
                active = 1'b0;
            end
            if (!to && age == w) begin
                m_ack   = 1'b1;
                m_rdata = ackd;
            end
        end else if (m_req) begin
            if (s_i && s_d) wd = RR ? !last_d : 1'b1;
            else            wd = s_d;
            last_d = wd;
            if (wd) begin
                chk("grant_we", 128'(m_we), 128'(s_dwe));
                chk("grant_addr", 128'(m_addr), 128'(s_daddr));
                if (s_dwe) chk("grant_wdata", 128'(m_wdata), 128'(s_dwdata));
            end else begin
                chk("grant_we", 128'(m_we), 128'(0));
                chk("grant_addr", 128'(m_addr), 128'(s_iaddr));
            end
            h_we    = m_we;
            h_addr  = m_addr;
            h_wdata = m_wdata;
            to      = !m_we && $urandom_range(0, 5) == 0;
            w       = $urandom_range(0, TO - 1);
            endc    = to ? TO : w + 1;
            ackd    = $urandom;
            active  = 1'b1;
            age     = 0;
            e.port  = wd;
            e.err   = to;
            e.cyc   = cyc + endc;
            if (to)        e.rdata = '0;
            else if (h_we) e.rdata = md_last;
            else           e.rdata = ackd;
            if (wd) md_last = e.rdata;
            else    mi_last = e.rdata;
            q.push_back(e);
            if (!to && w == 0) begin
                m_ack   = 1'b1;
                m_rdata = ackd;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            m_ack = 1'b1;
        end
    end

    logic [31:0] mon_i, mon_d;
    exp_t        g;

    always @(negedge clk) begin
        if (!n_reset) begin
            q.delete();
            mon_i = '0;
            mon_d = '0;
            chk("rst_ctrl", 128'({m_req, m_we, i_done, d_done, i_err, d_err}),
                128'(0));
            chk("rst_data", {m_addr, m_wdata, i_rdata, d_rdata}, 128'(0));
        end else if (i_done || d_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 128'({i_done, d_done}), 128'(0));
            end else begin
                g = q.pop_front();
                chk("done_port", 128'({i_done, d_done}),
                    g.port ? 128'(1) : 128'(2));
                chk("done_err", 128'(g.port ? d_err : i_err), 128'(g.err));
                chk("done_rdata", 128'(g.port ? d_rdata : i_rdata),
                    128'(g.rdata));
                chk("done_cycle", 128'(cyc), 128'(g.cyc));
                if (g.port) mon_d = g.rdata;
                else        mon_i = g.rdata;
            end
        end else begin
            chk("err_idle", 128'({i_err, d_err}), 128'(0));
            chk("rdata_hold", {i_rdata, d_rdata}, {mon_i, mon_d});
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 n_reset = 1'b1;
        stim_en = 1'b1;
        repeat (1500) @(negedge clk);

        for (int k = 0; k < 200 && !m_req; k++) @(negedge clk);
        chk("reset_wait_mreq", 128'(m_req), 128'(1));
        #2 n_reset = 1'b0;
        #1 chk("async_mreq_drop", 128'(m_req), 128'(0));
        repeat (3) @(negedge clk);
        #2 n_reset = 1'b1;
        #1 chk("post_reset_idle", 128'(m_req), 128'(0));
        repeat (1000) @(negedge clk);

        stim_en = 1'b0;
        for (int k = 0; k < 300 && (i_req || d_req || q.size() != 0); k++)
            @(negedge clk);
        chk("drain", 128'({i_req, d_req, q.size() != 0}), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single memory port between instruction fetch (read-only) and the data path (execute loads, writeback_mem stores). It latches the winning request, drives a req/ack memory handshake, returns read data and a one-cycle completion pulse to the winner, and aborts transactions the memory never acknowledges. It sits between fetch/writeback_mem and the memory model in cpu.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles m_req may wait for m_ack (≥1)
- clk  in  1  system clock, all state on rising edge
- n_reset  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request, held until i_done
- i_addr  in  ADDR_W  instruction address, stable while i_req
- i_rdata  out  DATA_W  fetched word, valid when i_done
- i_done  out  1  one-cycle completion pulse
- i_err  out  1  qualifies i_done: timeout abort
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_done && !d_we
- d_done  out  1  one-cycle completion pulse
- d_err  out  1  qualifies d_done: timeout abort
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid with m_ack
- m_ack  in  1  memory acknowledge, one cycle

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any req, select winner, latch addr/we/wdata into m_* registers, m_req←1, count←0, → BUSY. No req: stay.
- Selection: only one req → that one. Both → data port (fixed priority) unless round-robin compiled in.
- BUSY: m_* held constant. m_ack=1 → m_req←0; on a read, latch m_rdata into winner's rdata register; → DONE. Else count+1; count reaching TIMEOUT with no ack → m_req←0, winner err←1, winner rdata←0, → DONE.
- DONE: winner done=1 (err as set) for exactly this cycle; → IDLE; err cleared on exit.
- Stores never modify d_rdata. i_rdata/d_rdata hold last value between transactions.
- m_ack outside BUSY ignored. req deasserted mid-BUSY ignored (transaction completes). Requester must drop req the cycle after done; a req still high in IDLE is a new transaction.
- last_grant register updated on every IDLE→BUSY transition.

## Timing
- Reset (async, immediate): state IDLE, m_req/m_we/i_done/d_done/i_err/d_err = 0, m_addr/m_wdata/i_rdata/d_rdata = 0, count 0, last_grant = instruction. Reset mid-BUSY drops m_req asynchronously; no done pulse issued.
- Latency: req seen in cycle 0 (IDLE) → m_req high cycle 1 → ack in cycle 1 earliest → done cycle 2 → IDLE cycle 3. Min 3 cycles per transaction; each ack-wait cycle adds one.
- Timeout: m_req high for exactly TIMEOUT cycles, then DONE with err.
- count width $clog2(TIMEOUT+1); saturates, never wraps.
- m_ack in the same cycle count hits TIMEOUT: ack wins, no error.

## Configuration
- MEM_ARB_RR_EN defined: simultaneous requests granted to the port not in last_grant (alternating). First conflict after reset goes to data.
- Undefined: data port always wins conflicts; last_grant register removed.

## Structure
- Package mem_arb_pkg: state enum (ST_IDLE, ST_BUSY, ST_DONE), grant enum (GNT_I, GNT_D), default width constants.
- Sub-module mem_arb_timer: count register, clear/enable inputs, expired output at TIMEOUT.

## Test plan
- Single load: d_req, d_addr=0x10, m_ack one cycle after m_req with m_rdata=0xDEADBEEF → d_done in cycle 2, d_rdata=0xDEADBEEF, d_err=0.
- Conflict, fixed priority: i_req and d_req both high from cycle 0, ack immediate → data served first (d_done cycle 2), instruction next (i_done cycle 5).
- Conflict with MEM_ARB_RR_EN: both held high across four transactions → grants D,I,D,I.
- Store: d_we=1, d_addr=0x20, d_wdata=0x12345678, ack after 3 wait cycles → m_we=1 with those values held 4 cycles, d_done, d_rdata unchanged.
- Timeout: TIMEOUT=4, no m_ack → m_req high exactly 4 cycles, i_done with i_err=1, i_rdata=0; next request proceeds normally.
- Reset mid-BUSY: n_reset low during wait → m_req 0 immediately, no done, state IDLE after release.
